// File: rtl/systolic_pkg.sv
// Shared defaults and the feeder state encoding for the systolic array edge logic.
package systolic_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int N_DEF      = 4;
  localparam int K_W_DEF    = 8;

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    STREAM,
    FLUSH,
    DONE
  } feeder_state_t;

endpackage

// File: rtl/skew_line.sv
// DEPTH-stage data+valid delay line; DEPTH=0 degenerates to a wire.
module skew_line #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] src_data,
  input  logic              src_valid,
  output logic [DATA_W-1:0] dst_data,
  output logic              dst_valid
);

  if (DEPTH == 0) begin : g_wire
    assign dst_data  = src_data;
    assign dst_valid = src_valid;
  end else begin : g_pipe
    logic [DATA_W-1:0] data_pipe [DEPTH];
    logic [DEPTH-1:0]  valid_pipe;

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int s = 0; s < DEPTH; s++) data_pipe[s] <= '0;
        valid_pipe <= '0;
      end else begin
        data_pipe[0]  <= src_data;
        valid_pipe[0] <= src_valid;
        for (int s = 1; s < DEPTH; s++) begin
          data_pipe[s]  <= data_pipe[s-1];
          valid_pipe[s] <= valid_pipe[s-1];
        end
      end
    end

    assign dst_data  = data_pipe[DEPTH-1];
    assign dst_valid = valid_pipe[DEPTH-1];
  end

endmodule

// File: rtl/systolic_skew_feeder.sv
// Skews one N-lane operand vector per beat into diagonal wavefront order for the MAC array,
// pulses acc_clr before a tile and zero-flushes the skew lines after it.
module systolic_skew_feeder
  import systolic_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int N      = N_DEF,
  parameter int K_W    = K_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [K_W-1:0]      k_len,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [N*DATA_W-1:0] in_vec,
  output logic [N*DATA_W-1:0] out_vec,
  output logic [N-1:0]        out_valid,
  output logic                acc_clr,
  output logic                busy,
  output logic                done
);

  localparam int FW = (N > 1) ? $clog2(N) : 1;

  feeder_state_t     state, state_next;
  logic [K_W-1:0]    k_reg;
  logic [K_W-1:0]    beat_cnt;
  logic [FW-1:0]     flush_cnt;
  logic              beat;
  logic              last_beat;
  logic              flush_last;
  logic [N*DATA_W-1:0] stage_data;
  logic                stage_valid;

  assign beat       = in_valid & in_ready;
  assign last_beat  = beat && ((beat_cnt + K_W'(1)) == k_reg);
  // Only reachable for N>1, where N-2 is non-negative.
  assign flush_last = (int'(flush_cnt) == N - 2);

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    acc_clr    = 1'b0;
    done       = 1'b0;
    busy       = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_next = CLR;
      end
      CLR: begin
        acc_clr    = 1'b1;
        state_next = (k_reg == '0) ? DONE : STREAM;
      end
      STREAM: begin
        in_ready = 1'b1;
        if (last_beat) state_next = (N > 1) ? FLUSH : DONE;
      end
      FLUSH: begin
        if (flush_last) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      k_reg     <= '0;
      beat_cnt  <= '0;
      flush_cnt <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE && start) k_reg <= k_len;
      if (state == CLR)  beat_cnt <= '0;
      else if (beat)     beat_cnt <= beat_cnt + K_W'(1);
      if (state == FLUSH) flush_cnt <= flush_cnt + FW'(1);
      else                flush_cnt <= '0;
    end
  end

  // Common input stage; lanes shift every cycle so non-beats inject zeros.
  always_ff @(posedge clk) begin
    if (rst) begin
      stage_data  <= '0;
      stage_valid <= 1'b0;
    end else begin
      stage_data  <= beat ? in_vec : '0;
      stage_valid <= beat;
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_lane
    skew_line #(
      .DATA_W(DATA_W),
      .DEPTH (i)
    ) u_skew (
      .clk      (clk),
      .rst      (rst),
      .src_data (stage_data[i*DATA_W +: DATA_W]),
      .src_valid(stage_valid),
      .dst_data (out_vec[i*DATA_W +: DATA_W]),
      .dst_valid(out_valid[i])
    );
  end

endmodule
